// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
//
// APB slave exposing a 64-byte window of sixteen 32-bit registers.
// Registers 0..14 are read/write; register 15 is a read-only ID word
// (32'hA5B0_0000 | SLAVE_ID). The access phase can be stretched by
// WAIT_STATES cycles before Pready is raised.
//
// Handshake: a transfer is requested by a setup cycle (sel=1, Penable=0)
// followed by access cycles (sel=1, Penable=1). The transfer completes on
// the first rising edge where sel=1, Penable=1 and Pready=1. Dropping sel
// before that edge abandons the transfer without side effects.
//
// Parameters:
//   SLAVE_ID    - bit of Pselx that selects this slave (0..2)
//   BASE_ADDR   - base of the 64-byte window (bits [5:0] ignored)
//   WAIT_STATES - access cycles with Pready low before completion (0..7)
//
// Ports:
//   Hclk       in   clock, rising edge
//   Hresetn    in   asynchronous active-low reset
//   Pselx      in   one-hot peripheral select
//   Penable    in   0 = setup phase, 1 = access phase
//   Pwrite     in   1 = write, 0 = read
//   Paddr      in   byte address
//   Pwdata     in   write data
//   Prdata     out  read data, non-zero only while Pready=1 on a good read
//   Pready     out  registered transfer-complete flag
//   Pslverr    out  error response, qualified by Pready
//   state_dbg  out  current FSM state for observation
// ---------------------------------------------------------------------------
module apb_slave_regfile #(
    parameter int unsigned SLAVE_ID    = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_WAIT  = 2'd1;
    localparam logic [1:0]  ST_READY = 2'd2;

    localparam logic [1:0]  SEL_BIT   = 2'(SLAVE_ID);
    localparam logic [31:0] ID_VALUE  = 32'hA5B0_0000 | 32'(SLAVE_ID);
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);
    localparam logic [3:0]  ID_INDEX  = 4'hF;

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [31:0] regs [15];

    // Transfer context captured in the setup cycle; the access phase only
    // ever looks at these, never at the live bus.
    logic [3:0]  lat_idx;
    logic        lat_wr;
    logic [31:0] lat_wdata;
    logic        lat_err;

    logic        sel;
    logic        sel_unused;
    logic [3:0]  live_idx;
    logic        live_hit;
    logic        live_err;
    logic [31:0] live_rdata;
    logic [31:0] lat_rdata;

    assign sel        = Pselx[SEL_BIT];
    assign sel_unused = ^Pselx;
    assign state_dbg  = state;

    // Decode of the current bus address (used at the setup edge).
    assign live_idx = Paddr[5:2];
    assign live_hit = (Paddr[31:6] == BASE_ADDR[31:6]) && (Paddr[1:0] == 2'b00);
    assign live_err = !live_hit || (Pwrite && (live_idx == ID_INDEX));

    // With zero wait states Pready/Prdata are loaded on the setup edge itself,
    // so the read data must come from the live address, not the latch.
    always_comb begin
        live_rdata = '0;
        if (!live_err && !Pwrite) begin
            if (live_idx == ID_INDEX)
                live_rdata = ID_VALUE;
            else
                live_rdata = regs[live_idx];
        end
    end

    always_comb begin
        lat_rdata = '0;
        if (!lat_err && !lat_wr) begin
            if (lat_idx == ID_INDEX)
                lat_rdata = ID_VALUE;
            else
                lat_rdata = regs[lat_idx];
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            Pready    <= 1'b0;
            Pslverr   <= 1'b0;
            Prdata    <= '0;
            lat_idx   <= '0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
            lat_err   <= 1'b0;
            for (int i = 0; i < 15; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Access cycles without a preceding setup are ignored.
                    if (sel && !Penable) begin
                        lat_idx   <= live_idx;
                        lat_wr    <= Pwrite;
                        lat_wdata <= Pwdata;
                        lat_err   <= live_err;
                        cnt       <= WAIT_INIT;
                        if (WAIT_STATES == 0) begin
                            state   <= ST_READY;
                            Pready  <= 1'b1;
                            Pslverr <= live_err;
                            Prdata  <= live_rdata;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!sel) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        Pready  <= 1'b0;
                        Pslverr <= 1'b0;
                        Prdata  <= '0;
                    end else if (Penable) begin
                        // Raising Pready when the count hits 1 lets it be
                        // visible in access cycle WAIT_STATES+1.
                        if (cnt == 3'd1) begin
                            cnt     <= '0;
                            state   <= ST_READY;
                            Pready  <= 1'b1;
                            Pslverr <= lat_err;
                            Prdata  <= lat_rdata;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                end

                ST_READY: begin
                    // Completion (sel & Penable) or abort (!sel) both return
                    // to IDLE; only a completed, error-free write commits.
                    if (!sel || Penable) begin
                        if (sel && lat_wr && !lat_err)
                            regs[lat_idx] <= lat_wdata;
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        Pready  <= 1'b0;
                        Pslverr <= 1'b0;
                        Prdata  <= '0;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    Pready  <= 1'b0;
                    Pslverr <= 1'b0;
                    Prdata  <= '0;
                end
            endcase
        end
    end

endmodule
